// File: rtl/h2h_dma_pkg.sv
// Shared definitions for the h2h DMA controller: register map, bit positions,
// copy-engine state encoding and the STATUS word packing.
package h2h_dma_pkg;

    // Register word indices, taken from haddr[4:2]
    localparam logic [2:0] REG_SRC  = 3'd0;
    localparam logic [2:0] REG_DST  = 3'd1;
    localparam logic [2:0] REG_LEN  = 3'd2;
    localparam logic [2:0] REG_CTRL = 3'd3;
    localparam logic [2:0] REG_STAT = 3'd4;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_REM_LSB = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_FIN
    } dma_state_t;

    function automatic logic [31:0] status_word(input logic        busy,
                                                input logic        done,
                                                input logic [15:0] remaining);
        logic [31:0] w;
        w                             = '0;
        w[STAT_BUSY]                  = busy;
        w[STAT_DONE]                  = done;
        w[STAT_REM_LSB +: 16]         = remaining;
        return w;
    endfunction

endpackage

// File: rtl/h2h_ahb_regif.sv
// AHB-lite slave front end: address/data-phase capture and the DMA register file.
// Produces a START pulse and DONE-clear pulse in the cycle a write commits.
module h2h_ahb_regif
    import h2h_dma_pkg::*;
#(
    parameter int AW    = 32,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hsel,
    input  logic [31:0]      haddr,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [31:0]      hwdata,
    input  logic             hready,
    output logic [31:0]      hrdata,
    input  logic             busy,
    input  logic             done,
    input  logic [15:0]      remaining,
    output logic [AW-1:0]    src,
    output logic [AW-1:0]    dst,
    output logic [LEN_W-1:0] len,
    output logic             irq_en,
    output logic             start,
    output logic             done_clr
);

    logic        addr_phase;
    logic        dph_wr;
    logic [2:0]  dph_idx;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign addr_phase = hsel & hready & htrans[1];
    assign unused_ok  = &{1'b0, haddr[31:5], haddr[1:0], htrans[0]};

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        rd_mux = '0;
        case (haddr[4:2])
            REG_SRC:  rd_mux = 32'(src);
            REG_DST:  rd_mux = 32'(dst);
            REG_LEN:  rd_mux = 32'(len);
            REG_CTRL: rd_mux[CTRL_IRQ_EN] = irq_en;
            REG_STAT: rd_mux = status_word(busy, done, remaining);
            default:  rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dph_wr  <= 1'b0;
            dph_idx <= '0;
            hrdata  <= '0;
        end else begin
            dph_wr <= addr_phase & hwrite;
            if (addr_phase) begin
                dph_idx <= haddr[4:2];
            end
            if (addr_phase && !hwrite) begin
                hrdata <= rd_mux;
            end
        end
    end

    // START and DONE-clear act at the same edge the write data is committed
    assign start    = dph_wr && (dph_idx == REG_CTRL) && hwdata[CTRL_START];
    assign done_clr = dph_wr && (dph_idx == REG_STAT) && hwdata[STAT_DONE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            irq_en <= 1'b0;
        end else if (dph_wr) begin
            case (dph_idx)
                REG_SRC:  if (!busy) src <= hwdata[AW-1:0];
                REG_DST:  if (!busy) dst <= hwdata[AW-1:0];
                REG_LEN:  if (!busy) len <= hwdata[LEN_W-1:0];
                REG_CTRL: irq_en <= hwdata[CTRL_IRQ_EN];
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/h2h_dma_ctrl.sv
// Single-channel word-at-a-time memory-to-memory copy engine behind an AHB-lite
// register slave; raises a level interrupt when a transfer completes.
module h2h_dma_ctrl
    import h2h_dma_pkg::*;
#(
    parameter int AW    = 32,
    parameter int LEN_W = 16
) (
    input  logic          h2h_mclk,
    input  logic          h2h_rstn,
    input  logic          hsel,
    input  logic [31:0]   haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [31:0]   hwdata,
    input  logic          hready,
    output logic [31:0]   hrdata,
    output logic          hreadyout,
    output logic [1:0]    hresp,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata,
    output logic          irq
);

    logic [AW-1:0]    cfg_src;
    logic [AW-1:0]    cfg_dst;
    logic [LEN_W-1:0] cfg_len;
    logic             irq_en;
    logic             start;
    logic             done_clr;

    dma_state_t       state;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [LEN_W-1:0] remaining;
    logic             busy;
    logic             done;

    assign hreadyout = 1'b1;
    assign hresp     = 2'b00;

    h2h_ahb_regif #(
        .AW    (AW),
        .LEN_W (LEN_W)
    ) u_regif (
        .clk       (h2h_mclk),
        .rst_n     (h2h_rstn),
        .hsel      (hsel),
        .haddr     (haddr),
        .htrans    (htrans),
        .hwrite    (hwrite),
        .hwdata    (hwdata),
        .hready    (hready),
        .hrdata    (hrdata),
        .busy      (busy),
        .done      (done),
        .remaining (16'(remaining)),
        .src       (cfg_src),
        .dst       (cfg_dst),
        .len       (cfg_len),
        .irq_en    (irq_en),
        .start     (start),
        .done_clr  (done_clr)
    );

    // mem_wdata doubles as the one-word copy buffer: it is loaded on rvalid
    // and held untouched until the write is granted.
    always_ff @(posedge h2h_mclk or negedge h2h_rstn) begin
        if (!h2h_rstn) begin
            state     <= ST_IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            irq       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            irq <= done & irq_en;
            if (done_clr) begin
                done <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            rd_ptr    <= cfg_src;
                            wr_ptr    <= cfg_dst;
                            remaining <= cfg_len;
                            done      <= 1'b0;
                            busy      <= 1'b1;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= cfg_src;
                            state     <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        mem_wdata <= mem_rdata;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_ptr;
                        state     <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_gnt) begin
                        rd_ptr    <= rd_ptr + AW'(4);
                        wr_ptr    <= wr_ptr + AW'(4);
                        remaining <= remaining - LEN_W'(1);
                        mem_we    <= 1'b0;
                        if (remaining == LEN_W'(1)) begin
                            mem_req <= 1'b0;
                            state   <= ST_FIN;
                        end else begin
                            mem_addr <= rd_ptr + AW'(4);
                            state    <= ST_RD_REQ;
                        end
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_h2h_dma_ctrl.sv
// Self-checking bench for h2h_dma_ctrl: AHB register driver, a behavioural memory
// with random grant/latency, and expected copies computed from source contents.
module tb_h2h_dma_ctrl;

    localparam logic [31:0] BASE   = 32'h5000_0000;
    localparam logic [31:0] A_SRC  = BASE + 32'h00;
    localparam logic [31:0] A_DST  = BASE + 32'h04;
    localparam logic [31:0] A_LEN  = BASE + 32'h08;
    localparam logic [31:0] A_CTRL = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;
    localparam logic [31:0] A_UNM  = BASE + 32'h18;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel, hwrite, hready;
    logic [31:0] haddr, hwdata, hrdata;
    logic [1:0]  htrans, hresp;
    logic        hreadyout;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, irq;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    h2h_dma_ctrl #(.AW(32), .LEN_W(16)) dut (
        .h2h_mclk   (clk),
        .h2h_rstn   (rst_n),
        .hsel       (hsel),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hwdata     (hwdata),
        .hready     (hready),
        .hrdata     (hrdata),
        .hreadyout  (hreadyout),
        .hresp      (hresp),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .irq        (irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural memory ----------------
    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          gnt_mode = 0;        // 0: always grant, 1: random, 2: stall 5 cycles per request
    int          max_lat  = 0;
    bit          spurious_en = 1'b0;
    int unsigned cyc = 0;
    int unsigned last_wr_cyc = 0;
    int unsigned irq_rise_cyc = 0;
    int unsigned req_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (!mem_model.exists(a)) mem_model[a] = $urandom;
        return mem_model[a];
    endfunction

    initial begin
        bit          rd_out = 1'b0;
        int          lat_cnt = 0;
        int          stall_cnt = 0;
        logic [31:0] rd_addr = '0;
        bit          prev_stalled = 1'b0;
        logic [65:0] prev_vec = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_out = 1'b0; stall_cnt = 0; prev_stalled = 1'b0;
                mem_gnt = 1'b0; mem_rvalid = 1'b0;
                continue;
            end
            if (prev_stalled)
                check("req_stable", {14'b0, mem_req, mem_we, mem_addr, mem_wdata}, {14'b0, prev_vec});
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (rd_out) begin
                if (lat_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_read(rd_addr);
                    rd_out     = 1'b0;
                end else begin
                    lat_cnt--;
                end
            end else if (spurious_en && $urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1;
            end
            case (gnt_mode)
                0:       mem_gnt = 1'b1;
                1:       mem_gnt = 1'($urandom_range(0, 1));
                default: mem_gnt = (stall_cnt >= 5);
            endcase
            if (mem_req) begin
                req_cycles++;
                if (mem_gnt) begin
                    stall_cnt = 0;
                    if (mem_we) begin
                        wr_addr_q.push_back(mem_addr);
                        wr_data_q.push_back(mem_wdata);
                        mem_model[mem_addr] = mem_wdata;
                        last_wr_cyc = cyc + 1;
                    end else begin
                        rd_out  = 1'b1;
                        rd_addr = mem_addr;
                        lat_cnt = $urandom_range(0, max_lat);
                    end
                end else begin
                    stall_cnt++;
                end
            end
            prev_stalled = mem_req && !mem_gnt;
            prev_vec     = {mem_req, mem_we, mem_addr, mem_wdata};
        end
    end

    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (irq && !prev) irq_rise_cyc = cyc;
            prev = irq;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- AHB driver (called and returning at a negedge) ----------------
    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = a;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        @(negedge clk);
        check("ahb_ready_okay", {hreadyout, hresp}, 3'b100);
    endtask

    task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = a;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        d = hrdata;
        check("ahb_ready_okay", {hreadyout, hresp}, 3'b100);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] s;
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ahb_read(A_STAT, s);
            if (s[1]) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, ok, 1);
    endtask

    task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                            input int n, input bit ie, input bit poke);
        logic [31:0] exp_a[$];
        logic [31:0] exp_d[$];
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            exp_a.push_back(d + 32'(4 * i));
            exp_d.push_back(mem_read(s + 32'(4 * i)));
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        ahb_write(A_SRC, s);
        ahb_write(A_DST, d);
        ahb_write(A_LEN, 32'(n));
        ahb_write(A_CTRL, {30'b0, ie, 1'b1});
        if (poke) begin
            ahb_write(A_DST, 32'h0000_3000);
            ahb_write(A_CTRL, 32'h1);
            ahb_read(A_DST, r);
            check({tag, "_dst_locked"}, r, d);
            ahb_read(A_STAT, r);
            check({tag, "_busy_remaining"}, {r[31:16], r[1:0]}, {16'(n), 2'b01});
        end
        wait_done(tag);
        check({tag, "_nwrites"}, wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("%s_waddr%0d", tag, i), wr_addr_q[i], exp_a[i]);
            check($sformatf("%s_wdata%0d", tag, i), wr_data_q[i], exp_d[i]);
        end
        ahb_read(A_STAT, r);
        check({tag, "_status"}, r, 32'h2);
        check({tag, "_irq_level"}, irq, ie);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] r;
        int unsigned snap;
        bit found;
        hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hwdata = '0; hready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_port", {13'b0, mem_req, mem_we, mem_addr, mem_wdata, irq}, 80'h0);
        check("rst_ahb_out", {hrdata, hreadyout, hresp}, {32'h0, 1'b1, 2'b00});
        rst_n = 1'b1;
        @(negedge clk);

        // reset values and basic register access
        ahb_read(A_SRC, r);  check("rst_src", r, 0);
        ahb_read(A_DST, r);  check("rst_dst", r, 0);
        ahb_read(A_LEN, r);  check("rst_len", r, 0);
        ahb_read(A_CTRL, r); check("rst_ctrl", r, 0);
        ahb_read(A_STAT, r); check("rst_stat", r, 0);
        ahb_write(A_SRC, 32'h1000);
        ahb_write(A_DST, 32'h2000);
        ahb_write(A_LEN, 32'hABCD_0003);
        ahb_write(A_UNM, 32'hFFFF_FFFF);
        ahb_read(A_SRC, r);  check("rd_src", r, 32'h1000);
        ahb_read(A_DST, r);  check("rd_dst", r, 32'h2000);
        ahb_read(A_LEN, r);  check("rd_len", r, 32'h3);
        ahb_read(A_UNM, r);  check("rd_unmapped", r, 0);
        ahb_read(A_STAT, r); check("rd_stat_idle", r, 0);

        // 3-word copy with grant tied high and one-cycle read latency
        mem_model[32'h1000] = 32'hA0;
        mem_model[32'h1004] = 32'hA1;
        mem_model[32'h1008] = 32'hA2;
        run_copy("copy3", 32'h1000, 32'h2000, 3, 1'b0, 1'b0);

        // interrupt: rises one cycle after DONE, which follows the final write grant
        irq_rise_cyc = 0;
        run_copy("irq3", 32'h1000, 32'h2000, 3, 1'b1, 1'b0);
        check("irq_latency", irq_rise_cyc, last_wr_cyc + 2);
        ahb_read(A_CTRL, r); check("ctrl_readback", r, 32'h2);
        ahb_write(A_STAT, 32'h2);
        check("irq_hold_after_w1c", irq, 1);
        @(negedge clk);
        check("irq_clear_after_w1c", irq, 0);
        ahb_read(A_STAT, r); check("stat_after_w1c", r, 0);

        // stalled grants: stability is checked by the memory model on every stalled cycle
        gnt_mode = 2;
        run_copy("stall2", 32'h1000, 32'h2100, 2, 1'b0, 1'b1);
        run_copy("busy3", 32'h1000, 32'h2000, 3, 1'b0, 1'b1);
        gnt_mode = 0;

        // LEN=0: DONE without any memory request
        ahb_write(A_STAT, 32'h2);
        ahb_read(A_STAT, r); check("len0_pre_stat", r, 0);
        snap = req_cycles;
        ahb_write(A_LEN, 32'h0);
        ahb_write(A_CTRL, 32'h1);
        ahb_read(A_STAT, r); check("len0_stat", r, 32'h2);
        repeat (10) @(negedge clk);
        check("len0_no_req", req_cycles, snap);

        // address wrap past 2^32
        max_lat = 2;
        run_copy("wrap3", 32'hFFFF_FFF8, 32'h0000_4000, 3, 1'b0, 1'b0);

        // randomized copies with random grant, latency and stray rvalid pulses
        spurious_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] s;
            gnt_mode = $urandom_range(0, 1);
            max_lat  = $urandom_range(0, 3);
            s = ($urandom & 32'h0FFF_FFFC) | 32'h1000_0000;
            run_copy($sformatf("rand%0d", i), s, s ^ 32'h8000_0000,
                     $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'b0);
        end
        spurious_en = 1'b0;

        // reset while a write request is pending
        gnt_mode = 2;
        max_lat  = 0;
        ahb_write(A_SRC, 32'h1000);
        ahb_write(A_DST, 32'h2000);
        ahb_write(A_LEN, 32'h4);
        ahb_write(A_CTRL, 32'h3);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_reach_wr_req", found, 1);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_mem_port", {13'b0, mem_req, mem_we, mem_addr, mem_wdata, irq}, 80'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gnt_mode = 0;
        snap = req_cycles;
        @(negedge clk);
        ahb_read(A_SRC, r);  check("mid_src", r, 0);
        ahb_read(A_DST, r);  check("mid_dst", r, 0);
        ahb_read(A_LEN, r);  check("mid_len", r, 0);
        ahb_read(A_CTRL, r); check("mid_ctrl", r, 0);
        ahb_read(A_STAT, r); check("mid_stat", r, 0);
        repeat (5) @(negedge clk);
        check("mid_no_req", req_cycles, snap);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
